qam_demap: RTL and testbench

QAM_DEMAP -- requirements
Module: qam_demap

---
 rtl/qam_demap_pkg.sv | 32 +++
 rtl/qam_demap_fifo.sv | 52 +++++
 rtl/qam_demap.sv | 90 +++++++++
 tb/tb_qam_demap.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/qam_demap_pkg.sv
// Shared constellation constants and slicing helpers for the 16-QAM demapper.
// The mapper and the demapper both use these constants.
package qam_demap_pkg;

  localparam int LEVEL_INNER    = 8191;
  localparam int LEVEL_OUTER    = 24573;
  localparam int THRESH_DEFAULT = 16382;
  localparam int MARGIN_DEFAULT = 2048;
  localparam int FIFO_DEPTH     = 4;
  localparam int FIFO_W         = 5;
  localparam int FIFO_CW        = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [3:0] nib;
    logic       lc;
  } demap_t;

  // 17-bit magnitude so that -32768 maps to +32768 without overflow.
  function automatic logic [16:0] mag17(input logic signed [15:0] x);
    logic signed [16:0] e;
    e = {x[15], x};
    return x[15] ? 17'(-e) : e;
  endfunction

  function automatic logic near_edge(input logic [16:0] m, input logic [16:0] thr,
                                     input logic [16:0] mar);
    logic [16:0] d;
    d = (m >= thr) ? m - thr : thr - m;
    return (m < mar) || (d < mar);
  endfunction

endpackage

// File: rtl/qam_demap_fifo.sv
// First-word-fall-through FIFO with occupancy count; head is always visible on dout_o.
module qam_demap_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [W-1:0]                   din_i,
  input  logic                           pop_i,
  output logic [W-1:0]                   dout_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push_i && (cnt_q != CW'(DEPTH));
    do_pop  = pop_i && (cnt_q != '0);
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/qam_demap.sv
// 16-QAM hard-decision demapper: slice stage, 4-entry FWFT output buffer,
// delivered-symbol and low-confidence counters.
module qam_demap
  import qam_demap_pkg::*;
#(
  parameter int THRESH = THRESH_DEFAULT,
  parameter int MARGIN = MARGIN_DEFAULT
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic               valid_qam,
  input  logic signed [15:0] i,
  input  logic signed [15:0] q,
  output logic               ready_out,
  input  logic               ready_in,
  output logic               valid_demap,
  output logic [3:0]         odata,
  output logic               low_conf,
  output logic [15:0]        sym_cnt,
  output logic [15:0]        lowconf_cnt
);

  logic [16:0]         mag_i, mag_q;
  demap_t              slice_d, s1_data_q, s1_data_d, head;
  logic                s1_valid_q, s1_valid_d;
  logic                rdy_q;
  logic                accept, pop, fifo_empty;
  logic [FIFO_CW-1:0]  fifo_cnt;
  logic [15:0]         sym_cnt_q, sym_cnt_d, lc_cnt_q, lc_cnt_d;

  always_comb begin
    mag_i       = mag17(i);
    mag_q       = mag17(q);
    slice_d.nib = {i[15], q[15], mag_i < 17'(THRESH), mag_q < 17'(THRESH)};
    slice_d.lc  = near_edge(mag_i, 17'(THRESH), 17'(MARGIN)) ||
                  near_edge(mag_q, 17'(THRESH), 17'(MARGIN));
  end

  // rdy_q holds ready_out low during reset and releases it on the first edge after.
  assign ready_out = rdy_q &&
                     ((fifo_cnt + FIFO_CW'(s1_valid_q)) < FIFO_CW'(FIFO_DEPTH));
  assign accept    = en && valid_qam && ready_out;
  assign pop       = !fifo_empty && ready_in;

  always_comb begin
    s1_valid_d = accept;
    s1_data_d  = accept ? slice_d : s1_data_q;
    sym_cnt_d  = sym_cnt_q + 16'(pop);
    lc_cnt_d   = lc_cnt_q;
    if (pop && head.lc && (lc_cnt_q != '1)) lc_cnt_d = lc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      rdy_q      <= 1'b0;
      sym_cnt_q  <= '0;
      lc_cnt_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rdy_q      <= 1'b1;
      sym_cnt_q  <= sym_cnt_d;
      lc_cnt_q   <= lc_cnt_d;
    end
  end

  qam_demap_fifo #(
    .W     (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (res),
    .push_i  (s1_valid_q),
    .din_i   (s1_data_q),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign valid_demap = !fifo_empty;
  assign odata       = fifo_empty ? '0 : head.nib;
  assign low_conf    = !fifo_empty && head.lc;
  assign sym_cnt     = sym_cnt_q;
  assign lowconf_cnt = lc_cnt_q;

endmodule

// File: tb/tb_qam_demap.sv
// Scoreboard bench for qam_demap: accepted samples queue their expected nibble,
// an independent monitor checks every delivered nibble and the running counters.
module tb_qam_demap;

  logic               clk = 1'b0;
  logic               res, en, valid_qam, ready_in;
  logic signed [15:0] i, q;
  logic               ready_out, valid_demap, low_conf;
  logic [3:0]         odata;
  logic [15:0]        sym_cnt, lowconf_cnt;

  qam_demap dut (
    .clk(clk), .res(res), .en(en), .valid_qam(valid_qam), .i(i), .q(q),
    .ready_out(ready_out), .ready_in(ready_in), .valid_demap(valid_demap),
    .odata(odata), .low_conf(low_conf), .sym_cnt(sym_cnt), .lowconf_cnt(lowconf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] nib; logic lc; } exp_t;
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   pops_total = 0, lc_total = 0, acc_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: decisions straight from the threshold rules using integer arithmetic.
  function automatic exp_t ref_model(input int x, input int y);
    exp_t e;
    int ax, ay, dx, dy;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    dx = (ax > 16382) ? ax - 16382 : 16382 - ax;
    dy = (ay > 16382) ? ay - 16382 : 16382 - ay;
    e.nib = {x < 0, y < 0, ax < 16382, ay < 16382};
    e.lc  = (ax < 2048) || (dx < 2048) || (ay < 2048) || (dy < 2048);
    return e;
  endfunction

  function automatic logic signed [15:0] rand_sample();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom_range(0, 65535)) - 32768;
      1: v = 16382 + int'($urandom_range(0, 4200)) - 2100;
      2: v = int'($urandom_range(0, 2100));
      3: v = ($urandom_range(0, 1) != 0) ? 24573 : 8191;
      default: v = ($urandom_range(0, 1) != 0) ? 32767 : 32768;
    endcase
    if (v == 32768) return 16'sh8000;
    if ($urandom_range(0, 1) != 0) v = -v;
    return 16'(v);
  endfunction

  // Acceptance observer: the edge after this negedge takes the sample.
  always @(negedge clk) begin
    if (!res && en && valid_qam && ready_out) begin
      sb.push_back(ref_model(int'(i), int'(q)));
      acc_cnt++;
    end
  end

  // Monitor: counters reflect all pops decided at earlier negedges.
  always @(negedge clk) begin
    if (!res) begin
      check("sym_cnt", 32'(sym_cnt), 32'(pops_total % 65536));
      check("lowconf_cnt", 32'(lowconf_cnt), 32'((lc_total > 65535) ? 65535 : lc_total));
      if (valid_demap && ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(odata), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("odata", 32'(odata), 32'(e.nib));
          check("low_conf", 32'(low_conf), 32'(e.lc));
          pops_total++;
          if (e.lc) lc_total++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 res = 1'b1;
    #1;
    check("rst_ready_out", 32'(ready_out), 0);
    check("rst_valid", 32'(valid_demap), 0);
    check("rst_odata", 32'(odata), 0);
    check("rst_low_conf", 32'(low_conf), 0);
    check("rst_sym_cnt", 32'(sym_cnt), 0);
    check("rst_lc_cnt", 32'(lowconf_cnt), 0);
    sb.delete();
    pops_total = 0;
    lc_total   = 0;
    @(posedge clk);
    @(posedge clk);
    #2 res = 1'b0;
    #1 check("ready_after_fall", 32'(ready_out), 0);
    @(posedge clk);
    #1 check("ready_first_edge", 32'(ready_out), 1);
  endtask

  task automatic drain();
    int t = 0;
    valid_qam = 1'b0;
    ready_in  = 1'b1;
    while ((sb.size() != 0 || valid_demap) && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    check("drain_empty", 32'(sb.size()), 0);
  endtask

  task automatic single(input logic signed [15:0] xi, input logic signed [15:0] xq,
                        input logic [3:0] enib, input logic elc, input string nm);
    @(posedge clk);
    #1 en = 1'b1; valid_qam = 1'b1; i = xi; q = xq; ready_in = 1'b1;
    check({nm, "_ready"}, 32'(ready_out), 1);
    @(posedge clk);
    #1 valid_qam = 1'b0;
    check({nm, "_lat1"}, 32'(valid_demap), 0);
    @(posedge clk);
    #1 check({nm, "_lat2"}, 32'(valid_demap), 1);
    check({nm, "_nib"}, 32'(odata), 32'(enib));
    check({nm, "_lc"}, 32'(low_conf), 32'(elc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv[4];
    int bad_rdy, bad_val, acc0;
    lv = '{-24573, -8191, 8191, 24573};
    res = 1'b1; en = 1'b0; valid_qam = 1'b0; ready_in = 1'b0; i = '0; q = '0;
    do_reset();

    // Constellation sweep: nibble follows from sign and inner/outer level.
    foreach (lv[a]) begin
      foreach (lv[b]) begin
        single(16'(lv[a]), 16'(lv[b]),
               {lv[a] < 0, lv[b] < 0, lv[a] == 8191 || lv[a] == -8191,
                lv[b] == 8191 || lv[b] == -8191}, 1'b0, "sweep");
      end
    end
    single(-16'sd8191, 16'sd24573, 4'b1010, 1'b0, "ex_1010");
    single(16'sd16382, 16'sd0, 4'b0001, 1'b1, "bnd_thresh");
    single(16'sh8000, 16'sd16381, 4'b1001, 1'b1, "bnd_min");
    drain();

    // Backpressure: at most four samples in flight with the sink stalled.
    do_reset();
    acc0 = acc_cnt;
    @(posedge clk);
    #1 ready_in = 1'b0; en = 1'b1;
    repeat (12) begin
      valid_qam = 1'b1; i = rand_sample(); q = rand_sample();
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(acc_cnt - acc0), 4);
    check("bp_ready_low", 32'(ready_out), 0);
    drain();
    #1 check("bp_sym_cnt", 32'(sym_cnt), 4);

    // Streaming: one sample per cycle, no stalls.
    do_reset();
    acc0 = acc_cnt; bad_rdy = 0; bad_val = 0;
    ready_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      valid_qam = 1'b1; i = rand_sample(); q = rand_sample();
      if (!ready_out) bad_rdy++;
      if (k >= 2 && !valid_demap) bad_val++;
      @(posedge clk);
      #1;
    end
    check("stream_ready_drops", 32'(bad_rdy), 0);
    check("stream_valid_gaps", 32'(bad_val), 0);
    check("stream_accepted", 32'(acc_cnt - acc0), 100);
    drain();
    #1 check("stream_sym_cnt", 32'(sym_cnt), 100);

    // Random traffic with en, valid and ready_in all toggling.
    for (int k = 0; k < 800; k++) begin
      en        = ($urandom_range(0, 7) != 0);
      valid_qam = ($urandom_range(0, 3) != 0);
      ready_in  = ($urandom_range(0, 2) != 0);
      i = rand_sample(); q = rand_sample();
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with three entries buffered: nothing stale may appear afterwards.
    ready_in = 1'b0; en = 1'b1;
    acc0 = acc_cnt;
    while (acc_cnt - acc0 < 3) begin
      valid_qam = 1'b1; i = rand_sample(); q = rand_sample();
      @(posedge clk);
      #1;
    end
    valid_qam = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("pre_reset_valid", 32'(valid_demap), 1);
    do_reset();
    ready_in = 1'b1; bad_val = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (valid_demap) bad_val++;
    end
    check("post_reset_stale", 32'(bad_val), 0);

    // Counter limits: sym_cnt wraps after 65536 pops, lowconf_cnt saturates.
    valid_qam = 1'b1; i = '0; q = '0; en = 1'b1; ready_in = 1'b1;
    repeat (65540) @(posedge clk);
    #1 valid_qam = 1'b0;
    drain();
    #1;
    check("wrap_sym_cnt", 32'(sym_cnt), 4);
    check("sat_lc_cnt", 32'(lowconf_cnt), 65535);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
